// File: rtl/sdram_init_sequencer.sv
// SDRAM power-up sequencer: holds NOP/CKE during the power-up wait, then issues
// PRECHARGE ALL, N x AUTO REFRESH and LOAD MODE REGISTER before reporting init_done.
module sdram_init_sequencer #(
    parameter int unsigned       ADDR_W        = 11,
    parameter int unsigned       T_RP          = 3,
    parameter int unsigned       T_RC          = 9,
    parameter int unsigned       T_MRD         = 2,
    parameter int unsigned       REFRESH_COUNT = 8,
    parameter logic [ADDR_W-1:0] MODE_REG      = ADDR_W'(11'b000_0_00_010_0_000)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sdram_init_n,
    input  logic              sdram_ready,
    output logic              cke,
    output logic [3:0]        cmd,
    output logic [ADDR_W-1:0] addr,
    output logic [1:0]        ba,
    output logic              busy,
    output logic              init_done
);

    localparam int unsigned T_MAX = (T_RP > T_RC) ? ((T_RP > T_MRD) ? T_RP : T_MRD)
                                                  : ((T_RC > T_MRD) ? T_RC : T_MRD);
    localparam int unsigned CNT_W = $clog2(T_MAX + 1);

    localparam logic [3:0] CMD_NOP  = 4'b0111;
    localparam logic [3:0] CMD_PRE  = 4'b0010;
    localparam logic [3:0] CMD_AREF = 4'b0001;
    localparam logic [3:0] CMD_LMR  = 4'b0000;

    typedef enum logic [3:0] {
        S_IDLE, S_PWRUP, S_PRECH, S_TRP, S_REF, S_TRC, S_LMR, S_TMRD, S_DONE
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   wait_cnt;
    logic [3:0]         ref_cnt;
    logic               wait_last;
    logic               more_ref;
    logic               abort;

    logic               cke_c;
    logic [3:0]         cmd_c;
    logic [ADDR_W-1:0]  addr_c;
    logic [1:0]         ba_c;
    logic               busy_c;
    logic               init_done_c;

    // Wait states last T_x-1 cycles; the command cycle itself supplies the remaining one.
    assign wait_last = (wait_cnt == CNT_W'(1));
    assign abort     = !sdram_init_n && (state != S_IDLE) && (state != S_PWRUP);

    // In REF the counter has not yet absorbed the refresh being issued.
    always_comb begin
        more_ref = 1'b0;
        if (state == S_REF)
            more_ref = ({1'b0, ref_cnt} + 5'd1) < 5'(REFRESH_COUNT);
        else
            more_ref = {1'b0, ref_cnt} < 5'(REFRESH_COUNT);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (!sdram_init_n) state_n = S_PWRUP;
            S_PWRUP: if (sdram_init_n)  state_n = S_PRECH;
            S_PRECH: state_n = (T_RP > 1) ? S_TRP : S_REF;
            S_TRP:   if (wait_last) state_n = S_REF;
            S_REF: begin
                if (T_RC > 1)      state_n = S_TRC;
                else if (more_ref) state_n = S_REF;
                else               state_n = S_LMR;
            end
            S_TRC:   if (wait_last) state_n = more_ref ? S_REF : S_LMR;
            S_LMR:   state_n = (T_MRD > 1) ? S_TMRD : S_DONE;
            S_TMRD:  if (wait_last) state_n = S_DONE;
            S_DONE:  state_n = S_DONE;
            default: state_n = S_IDLE;
        endcase
        if (abort) state_n = S_PWRUP;
    end

    // Wait counter reloads on each command cycle; refresh count restarts with every sequence.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
            ref_cnt  <= '0;
        end else begin
            case (state)
                S_PRECH: wait_cnt <= CNT_W'(T_RP - 1);
                S_REF:   wait_cnt <= CNT_W'(T_RC - 1);
                S_LMR:   wait_cnt <= CNT_W'(T_MRD - 1);
                default: if (wait_cnt != '0) wait_cnt <= wait_cnt - CNT_W'(1);
            endcase
            if (state_n == S_PRECH || state_n == S_PWRUP)
                ref_cnt <= '0;
            else if (state == S_REF)
                ref_cnt <= ref_cnt + 4'd1;
        end
    end

    always_comb begin
        cke_c       = (state != S_IDLE);
        cmd_c       = CMD_NOP;
        addr_c      = '0;
        ba_c        = 2'b00;
        busy_c      = 1'b0;
        init_done_c = 1'b0;
        case (state)
            S_PRECH: begin
                cmd_c      = CMD_PRE;
                addr_c[10] = 1'b1;
                busy_c     = 1'b1;
            end
            S_REF: begin
                cmd_c  = CMD_AREF;
                busy_c = 1'b1;
            end
            S_LMR: begin
                cmd_c  = CMD_LMR;
                addr_c = MODE_REG;
                busy_c = 1'b1;
            end
            S_TRP, S_TRC, S_TMRD: busy_c = 1'b1;
            // init_done trails the fall of busy by one cycle
            S_DONE:  init_done_c = !busy && sdram_ready;
            default: ;
        endcase
        if (abort) begin
            cmd_c       = CMD_NOP;
            addr_c      = '0;
            ba_c        = 2'b00;
            busy_c      = 1'b0;
            init_done_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cke       <= 1'b0;
            cmd       <= CMD_NOP;
            addr      <= '0;
            ba        <= 2'b00;
            busy      <= 1'b0;
            init_done <= 1'b0;
        end else begin
            cke       <= cke_c;
            cmd       <= cmd_c;
            addr      <= addr_c;
            ba        <= ba_c;
            busy      <= busy_c;
            init_done <= init_done_c;
        end
    end

endmodule
